// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types, constants and colour helper for the memory-card board
package memory_pkg;

  typedef enum logic [1:0] {
    HIDDEN  = 2'd0,
    UP      = 2'd1,
    MATCHED = 2'd2
  } card_state_t;

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    CMP,
    SHOW,
    WIN
  } ctrl_state_t;

  localparam int NUM_PAIRS = 8;

  // CARTA1..CARTA8 as 24-bit RGB, indexed by colour code; shared with the pattern generator
  localparam logic [23:0] CARTA_RGB [NUM_PAIRS] = '{
    24'hE53935, 24'h43A047, 24'h1E88E5, 24'hFDD835,
    24'h8E24AA, 24'h00ACC1, 24'hFB8C00, 24'hF5F5F5
  };

  // Cards i and i+8 always share a colour, whatever the offset
  function automatic logic [2:0] card_color(input logic [3:0] idx, input logic [2:0] offset);
    return idx[2:0] + offset;
  endfunction

endpackage

// File: rtl/memory_board_ctrl_if.sv
// rtl/memory_board_ctrl_if.sv - selection handshake and pattern-generator query port
interface memory_board_ctrl_if;
  import memory_pkg::*;

  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic        sel_ready;
  logic        sel_reject;
  logic [3:0]  qry_idx;
  card_state_t qry_state;
  logic [2:0]  qry_color;

  modport master (
    output sel_valid, sel_idx, qry_idx,
    input  sel_ready, sel_reject, qry_state, qry_color
  );

  modport slave (
    input  sel_valid, sel_idx, qry_idx,
    output sel_ready, sel_reject, qry_state, qry_color
  );

endinterface

// File: rtl/frame_hold_timer.sv
// rtl/frame_hold_timer.sv - 8-bit frame counter: load, decrement on frame_start, zero flag
module frame_hold_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       frame_start,
  output logic       zero
);

  logic [7:0] count;

  // Load wins over a coincident frame_start; the count parks at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (frame_start && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/memory_board_ctrl.sv
// rtl/memory_board_ctrl.sv - pair-matching game sequencer with frame-synchronised board shadow
module memory_board_ctrl
  import memory_pkg::*;
#(
  parameter int SHOW_FRAMES = 60,
  parameter int NUM_CARDS   = 16
) (
  input  logic                VGA_CLK_IN,
  input  logic                rst_n,
  input  logic                frame_start,
  memory_board_ctrl_if.slave  bus,
  output logic                turn,
  output logic [3:0]          score0,
  output logic [3:0]          score1,
  output logic                game_over
);

  localparam logic [3:0] LAST_PAIR  = 4'(NUM_PAIRS - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(SHOW_FRAMES);

  ctrl_state_t state, state_nxt;
  card_state_t card   [NUM_CARDS];
  card_state_t shadow [NUM_CARDS];

  logic [3:0] first_idx;
  logic [3:0] second_idx;
  logic [3:0] pairs;
  logic [2:0] free_cnt;
  logic [2:0] offset;
  logic       offset_locked;
  logic       reject_q;

  logic sel_ready_c;
  logic accept;
  logic pick_hidden;
  logic match_hit;
  logic timer_load;
  logic hide_pair;
  logic hold_zero;

  frame_hold_timer u_hold (
    .clk         (VGA_CLK_IN),
    .rst_n       (rst_n),
    .load        (timer_load),
    .load_value  (HOLD_LOAD),
    .frame_start (frame_start),
    .zero        (hold_zero)
  );

  always_comb begin
    state_nxt   = state;
    sel_ready_c = 1'b0;
    game_over   = 1'b0;
    accept      = 1'b0;
    pick_hidden = 1'b0;
    match_hit   = 1'b0;
    timer_load  = 1'b0;
    hide_pair   = 1'b0;
    case (state)
      PICK1, PICK2: begin
        sel_ready_c = 1'b1;
        accept      = bus.sel_valid;
        // Re-picking the first card fails this test because it is already UP
        pick_hidden = accept && (card[bus.sel_idx] == HIDDEN);
        if (pick_hidden) begin
          state_nxt = (state == PICK1) ? PICK2 : CMP;
        end
      end
      CMP: begin
        if (card_color(first_idx, offset) == card_color(second_idx, offset)) begin
          match_hit = 1'b1;
          state_nxt = (pairs == LAST_PAIR) ? WIN : PICK1;
        end else begin
          timer_load = 1'b1;
          state_nxt  = SHOW;
        end
      end
      SHOW: begin
        if (hold_zero) begin
          hide_pair = 1'b1;
          state_nxt = PICK1;
        end
      end
      WIN: begin
        game_over = 1'b1;
      end
      default: begin
        state_nxt = PICK1;
      end
    endcase
  end

  always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PICK1;
      first_idx     <= 4'd0;
      second_idx    <= 4'd0;
      pairs         <= 4'd0;
      free_cnt      <= 3'd0;
      offset        <= 3'd0;
      offset_locked <= 1'b0;
      reject_q      <= 1'b0;
      turn          <= 1'b0;
      score0        <= 4'd0;
      score1        <= 4'd0;
      for (int i = 0; i < NUM_CARDS; i++) begin
        card[i]   <= HIDDEN;
        shadow[i] <= HIDDEN;
      end
    end else begin
      state    <= state_nxt;
      free_cnt <= free_cnt + 3'd1;
      reject_q <= accept && !pick_hidden;

      // Non-blocking copy: the shadow takes the board as it stood before this edge
      if (frame_start) begin
        for (int i = 0; i < NUM_CARDS; i++) begin
          shadow[i] <= card[i];
        end
      end

      if (accept && !offset_locked) begin
        offset        <= free_cnt;
        offset_locked <= 1'b1;
      end

      if (pick_hidden) begin
        card[bus.sel_idx] <= UP;
        if (state == PICK1) begin
          first_idx <= bus.sel_idx;
        end else begin
          second_idx <= bus.sel_idx;
        end
      end

      if (match_hit) begin
        card[first_idx]  <= MATCHED;
        card[second_idx] <= MATCHED;
        pairs            <= pairs + 4'd1;
        if (turn) begin
          score1 <= score1 + 4'd1;
        end else begin
          score0 <= score0 + 4'd1;
        end
      end

      if (hide_pair) begin
        card[first_idx]  <= HIDDEN;
        card[second_idx] <= HIDDEN;
        turn             <= ~turn;
      end
    end
  end

  assign bus.sel_ready  = sel_ready_c;
  assign bus.sel_reject = reject_q;
  assign bus.qry_state  = shadow[bus.qry_idx];
  assign bus.qry_color  = card_color(bus.qry_idx, offset);

endmodule

// File: tb/tb_memory_board_ctrl.sv
// tb/tb_memory_board_ctrl.sv - self-checking bench for memory_board_ctrl
module tb_memory_board_ctrl;
  import memory_pkg::*;

  localparam int SHOW_FRAMES = 3;
  localparam int RAND_BUDGET = 20000;

  logic VGA_CLK_IN = 1'b0;
  logic rst_n      = 1'b0;
  logic frame_start = 1'b0;
  logic turn;
  logic [3:0] score0, score1;
  logic game_over;

  memory_board_ctrl_if bus ();

  memory_board_ctrl #(.SHOW_FRAMES(SHOW_FRAMES), .NUM_CARDS(16)) dut (
    .VGA_CLK_IN (VGA_CLK_IN),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .bus        (bus),
    .turn       (turn),
    .score0     (score0),
    .score1     (score1),
    .game_over  (game_over)
  );

  always #10 VGA_CLK_IN = ~VGA_CLK_IN;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: game rules at card/turn level
  int m_card [16];
  int m_shadow [16];
  int m_phase;          // 0 first pick, 1 second pick, 2 compare, 3 showing, 4 won
  int m_first, m_second, m_turn, m_pairs, m_hold, m_cnt, m_off;
  int m_score [2];
  bit m_locked, m_reject;

  logic [11:0] dut_status;
  logic [31:0] rd_state;
  logic [47:0] rd_color;
  assign dut_status = {bus.sel_ready, bus.sel_reject, turn, score0, score1, game_over};

  function void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_card[i] = 0;
      m_shadow[i] = 0;
    end
    m_phase = 0; m_first = 0; m_second = 0; m_turn = 0; m_pairs = 0;
    m_hold = 0; m_cnt = 0; m_off = 0; m_locked = 0; m_reject = 0;
    m_score[0] = 0; m_score[1] = 0;
  endfunction

  function void model_edge();
    int idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    idx = int'(bus.sel_idx);
    m_reject = 0;
    if (frame_start) m_shadow = m_card;
    case (m_phase)
      0, 1: if (bus.sel_valid) begin
        if (!m_locked) begin
          m_off = m_cnt;
          m_locked = 1;
        end
        if (m_card[idx] == 0) begin
          m_card[idx] = 1;
          if (m_phase == 0) begin m_first = idx; m_phase = 1; end
          else begin m_second = idx; m_phase = 2; end
        end else begin
          m_reject = 1;
        end
      end
      2: if ((m_first % 8) == (m_second % 8)) begin
        m_card[m_first] = 2;
        m_card[m_second] = 2;
        m_score[m_turn]++;
        m_pairs++;
        m_phase = (m_pairs == 8) ? 4 : 0;
      end else begin
        m_hold = SHOW_FRAMES;
        m_phase = 3;
      end
      3: if (m_hold == 0) begin
        m_card[m_first] = 0;
        m_card[m_second] = 0;
        m_turn ^= 1;
        m_phase = 0;
      end else if (frame_start) begin
        m_hold--;
      end
      default: ;
    endcase
    m_cnt = (m_cnt + 1) % 8;
  endfunction

  function logic [11:0] exp_status();
    return {(m_phase < 2), m_reject, 1'(m_turn), 4'(m_score[0]), 4'(m_score[1]), (m_phase == 4)};
  endfunction

  function logic [31:0] exp_board();
    logic [31:0] v;
    for (int i = 0; i < 16; i++) v[2*i +: 2] = 2'(m_shadow[i]);
    return v;
  endfunction

  function logic [47:0] exp_colors();
    logic [47:0] v;
    for (int i = 0; i < 16; i++) v[3*i +: 3] = 3'((i + m_off) % 8);
    return v;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge VGA_CLK_IN);
    #1;
  endtask

  task automatic read_board();
    for (int i = 0; i < 16; i++) begin
      bus.qry_idx = 4'(i);
      #1;
      rd_state[2*i +: 2] = bus.qry_state;
      rd_color[3*i +: 3] = bus.qry_color;
    end
  endtask

  task automatic select(input int idx);
    bus.sel_valid = 1'b1;
    bus.sel_idx = 4'(idx);
    tick();
    bus.sel_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    frame_start = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_idx = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL reset_board: got %h expected %h", rd_state, exp_board());
    else n_pass++;
    n_checks++;
    if (rd_color !== exp_colors()) $display("FAIL reset_colors: got %h expected %h", rd_color, exp_colors());
    else n_pass++;
    n_checks++;
    if (dut_status !== exp_status()) $display("FAIL reset_status: got %h expected %h", dut_status, exp_status());
    else n_pass++;
  endtask

  task automatic test_match();
    do_reset();
    select(2);
    select(10);
    tick();
    pulse_frame();
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL match_board: got %h expected %h", rd_state, exp_board());
    else n_pass++;
    n_checks++;
    if (dut_status !== exp_status()) $display("FAIL match_status: got %h expected %h", dut_status, exp_status());
    else n_pass++;
  endtask

  task automatic test_mismatch();
    do_reset();
    select(3);
    select(4);
    tick();
    n_checks++;
    if (dut_status !== exp_status()) $display("FAIL show_enter: got %h expected %h", dut_status, exp_status());
    else n_pass++;
    for (int p = 1; p <= 4; p++) begin
      pulse_frame();
      tick();
      tick();
      n_checks++;
      if (dut_status !== exp_status()) $display("FAIL show_status_%0d: got %h expected %h", p, dut_status, exp_status());
      else n_pass++;
      read_board();
      n_checks++;
      if (rd_state !== exp_board()) $display("FAIL show_board_%0d: got %h expected %h", p, rd_state, exp_board());
      else n_pass++;
      if (p == 1) begin
        select(7);
        n_checks++;
        if (dut_status !== exp_status()) $display("FAIL show_ignore: got %h expected %h", dut_status, exp_status());
        else n_pass++;
      end
    end
  endtask

  task automatic test_reject();
    do_reset();
    select(5);
    select(5);
    n_checks++;
    if (dut_status !== exp_status()) $display("FAIL reject_same: got %h expected %h", dut_status, exp_status());
    else n_pass++;
    tick();
    n_checks++;
    if (dut_status !== exp_status()) $display("FAIL reject_pulse_end: got %h expected %h", dut_status, exp_status());
    else n_pass++;
    select(13);
    tick();
    select(5);
    n_checks++;
    if (dut_status !== exp_status()) $display("FAIL reject_matched: got %h expected %h", dut_status, exp_status());
    else n_pass++;
    tick();
    pulse_frame();
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL reject_board: got %h expected %h", rd_state, exp_board());
    else n_pass++;
  endtask

  task automatic test_shadow();
    do_reset();
    select(6);
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL shadow_no_frame: got %h expected %h", rd_state, exp_board());
    else n_pass++;
    pulse_frame();
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL shadow_one_frame: got %h expected %h", rd_state, exp_board());
    else n_pass++;
    frame_start = 1'b1;
    select(7);
    frame_start = 1'b0;
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL shadow_same_cycle: got %h expected %h", rd_state, exp_board());
    else n_pass++;
    pulse_frame();
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL shadow_next_frame: got %h expected %h", rd_state, exp_board());
    else n_pass++;
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    select(1);
    select(2);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_status !== exp_status()) $display("FAIL async_reset_status: got %h expected %h", dut_status, exp_status());
    else n_pass++;
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL async_reset_board: got %h expected %h", rd_state, exp_board());
    else n_pass++;
    tick();
    rst_n = 1'b1;
    pulse_frame();
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL post_reset_board: got %h expected %h", rd_state, exp_board());
    else n_pass++;
  endtask

  task automatic test_random_game();
    int cycles;
    bit colors_checked;
    do_reset();
    repeat ($urandom_range(0, 11)) tick();
    cycles = 0;
    colors_checked = 0;
    while (m_phase != 4 && cycles < RAND_BUDGET) begin
      frame_start = ($urandom_range(0, 3) == 0);
      bus.sel_valid = ($urandom_range(0, 9) < 7);
      if (m_phase == 1 && $urandom_range(0, 1) == 1) bus.sel_idx = 4'(m_first ^ 8);
      else bus.sel_idx = 4'($urandom_range(0, 15));
      tick();
      cycles++;
      n_checks++;
      if (dut_status !== exp_status()) $display("FAIL rand_status@%0d: got %h expected %h", cycles, dut_status, exp_status());
      else n_pass++;
      if (m_locked && !colors_checked) begin
        colors_checked = 1;
        read_board();
        n_checks++;
        if (rd_color !== exp_colors()) $display("FAIL rand_colors: got %h expected %h", rd_color, exp_colors());
        else n_pass++;
      end
    end
    frame_start = 1'b0;
    bus.sel_valid = 1'b0;
    n_checks++;
    if (game_over !== 1'b1) $display("FAIL rand_game_over: got %b expected 1 after %0d cycles", game_over, cycles);
    else n_pass++;
    n_checks++;
    if (5'(score0) + 5'(score1) !== 5'(m_pairs)) $display("FAIL rand_score_sum: got %0d expected %0d", score0 + score1, m_pairs);
    else n_pass++;
    pulse_frame();
    read_board();
    n_checks++;
    if (rd_state !== exp_board()) $display("FAIL rand_final_board: got %h expected %h", rd_state, exp_board());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      select($urandom_range(0, 15));
      n_checks++;
      if (dut_status !== exp_status()) $display("FAIL won_ignore_%0d: got %h expected %h", k, dut_status, exp_status());
      else n_pass++;
    end
  endtask

  initial begin
    bus.sel_valid = 1'b0;
    bus.sel_idx = 4'd0;
    bus.qry_idx = 4'd0;
    model_reset();
    test_reset();
    test_match();
    test_mismatch();
    test_reject();
    test_shadow();
    test_reset_mid_show();
    test_random_game();
    test_random_game();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
